// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem handshake, output slot + one-entry skid.
// Optional IF_MISALIGN_CHECK_EN: misaligned redirects yield a flagged bubble slot instead of a fetch.
module if_fetch_unit #(
  parameter int unsigned               INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0]    RESET_PC    = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [INSTR_WIDTH-1:0] redirect_pc_i,
  output logic                   imem_req_o,
  output logic [INSTR_WIDTH-1:0] imem_addr_o,
  input  logic                   imem_ready_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [INSTR_WIDTH-1:0] pc_o,
  output logic                   valid_o,
  output logic                   fetch_busy_o
`ifdef IF_MISALIGN_CHECK_EN
  ,output logic                  misalign_o
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t                 r_state, w_state;
  logic [INSTR_WIDTH-1:0] r_fpc, w_fpc;
  logic [INSTR_WIDTH-1:0] r_tgt, w_tgt;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr;
  logic [INSTR_WIDTH-1:0] r_pc, w_pc;
  logic                   r_valid, w_valid;
  logic [INSTR_WIDTH-1:0] r_sk_instr, w_sk_instr;
  logic [INSTR_WIDTH-1:0] r_sk_pc, w_sk_pc;
  logic                   r_sk_valid, w_sk_valid;
  logic                   r_lock, w_lock;
  logic                   r_busy, w_busy;
`ifdef IF_MISALIGN_CHECK_EN
  logic                   r_mis, w_mis;
`endif

  logic                   w_req;
  logic                   w_done;
  logic                   w_consume;
  logic                   w_allow;
  logic                   w_mis_redir;
  logic [INSTR_WIDTH-1:0] w_tgt_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_BOOT;
      r_fpc      <= RESET_PC;
      r_tgt      <= RESET_PC;
      r_instr    <= '0;
      r_pc       <= '0;
      r_valid    <= 1'b0;
      r_sk_instr <= '0;
      r_sk_pc    <= '0;
      r_sk_valid <= 1'b0;
      r_lock     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      r_mis      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_fpc      <= w_fpc;
      r_tgt      <= w_tgt;
      r_instr    <= w_instr;
      r_pc       <= w_pc;
      r_valid    <= w_valid;
      r_sk_instr <= w_sk_instr;
      r_sk_pc    <= w_sk_pc;
      r_sk_valid <= w_sk_valid;
      r_lock     <= w_lock;
      r_busy     <= w_busy;
`ifdef IF_MISALIGN_CHECK_EN
      r_mis      <= w_mis;
`endif
    end
  end

  always_comb begin
    w_state    = r_state;
    w_fpc      = r_fpc;
    w_tgt      = r_tgt;
    w_instr    = r_instr;
    w_pc       = r_pc;
    w_valid    = r_valid;
    w_sk_instr = r_sk_instr;
    w_sk_pc    = r_sk_pc;
    w_sk_valid = r_sk_valid;
    w_lock     = r_lock;
    w_allow    = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    w_mis       = r_mis;
    w_tgt_pc    = redirect_pc_i;
    w_mis_redir = |redirect_pc_i[1:0];
`else
    w_tgt_pc    = redirect_pc_i & ~(INSTR_WIDTH'(3));
    w_mis_redir = 1'b0;
`endif
    w_req     = (r_state == S_REQ) || (r_state == S_DRAIN);
    w_done    = w_req && imem_ready_i;
    w_consume = r_valid && !stall_i;
    w_busy    = w_req && !w_done;

    if (redirect_i) begin
      // Slot consumed this edge is the delay slot; everything else is flushed.
      w_instr    = '0;
      w_pc       = '0;
      w_valid    = 1'b0;
      w_sk_instr = '0;
      w_sk_pc    = '0;
      w_sk_valid = 1'b0;
      w_lock     = w_mis_redir;
`ifdef IF_MISALIGN_CHECK_EN
      w_mis      = w_mis_redir;
      if (w_mis_redir) begin
        w_valid = 1'b1;
        w_pc    = w_tgt_pc;
      end
`endif
      if (w_req && !w_done) begin
        w_state = S_DRAIN;
        w_tgt   = w_tgt_pc;
      end else begin
        w_fpc   = w_tgt_pc;
        w_state = w_mis_redir ? S_HOLD : S_REQ;
      end
    end else begin
      if (w_consume) begin
        w_instr    = r_sk_instr;
        w_pc       = r_sk_pc;
        w_valid    = r_sk_valid;
        w_sk_instr = '0;
        w_sk_pc    = '0;
        w_sk_valid = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        w_mis      = 1'b0;
`endif
      end
      // The skid is always empty while a request is outstanding, so a completion never overwrites it.
      if (w_done && (r_state == S_REQ)) begin
        if (!r_valid || w_consume) begin
          w_instr = imem_rdata_i;
          w_pc    = r_fpc;
          w_valid = 1'b1;
        end else begin
          w_sk_instr = imem_rdata_i;
          w_sk_pc    = r_fpc;
          w_sk_valid = 1'b1;
        end
        w_fpc = r_fpc + INSTR_WIDTH'(4);
      end
      w_allow = !w_sk_valid && !(r_valid && stall_i) && !r_lock;
      unique case (r_state)
        S_BOOT:  w_state = S_REQ;
        S_REQ:   if (w_done) w_state = w_allow ? S_REQ : S_HOLD;
        S_HOLD:  if (w_allow) w_state = S_REQ;
        S_DRAIN: if (w_done) begin
                   w_fpc   = r_tgt;
                   w_state = r_lock ? S_HOLD : S_REQ;
                 end
        default: w_state = S_BOOT;
      endcase
    end
  end

  assign imem_req_o   = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign imem_addr_o  = r_fpc;
  assign instr_o      = r_instr;
  assign pc_o         = r_pc;
  assign valid_o      = r_valid;
  assign fetch_busy_o = r_busy;
`ifdef IF_MISALIGN_CHECK_EN
  assign misalign_o   = r_mis;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: boot stream, stall/skid, redirect drain, delay slot, wrap, misalign.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        fetch_busy_o;
`ifdef IF_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(.INSTR_WIDTH(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .valid_o      (valid_o),
    .fetch_busy_o (fetch_busy_o)
`ifdef IF_MISALIGN_CHECK_EN
    ,.misalign_o  (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  assign imem_rdata_i = imem_ready_i ? instr_of(imem_addr_o) : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its boot cycle; the next tick issues the first request.
  task automatic do_reset();
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_ready_i = 1'b1;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_ready_i = 1'b1;
    tick(); tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %h exp 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'hBFC0_0000) begin errors++; $display("FAIL rst_addr got %h exp bfc00000", imem_addr_o); end
    checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", valid_o); end
    checks++; if (fetch_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %h exp 0", fetch_busy_o); end
`ifdef IF_MISALIGN_CHECK_EN
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_mis got %h exp 0", misalign_o); end
`endif
  endtask

  task automatic test_boot_stream();
    logic [31:0] exp_pc;
    do_reset();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL boot_noreq got %h exp 0", imem_req_o); end
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hBFC0_0000) begin errors++; $display("FAIL first_req got %h/%h exp 1/bfc00000", imem_req_o, imem_addr_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL first_valid got %h exp 0", valid_o); end
    exp_pc = 32'hBFC0_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid_o !== 1'b1 || pc_o !== exp_pc || instr_o !== instr_of(exp_pc)) begin
        errors++; $display("FAIL stream_%0d got v%h pc %h in %h exp v1 pc %h in %h", i, valid_o, pc_o, instr_o, exp_pc, instr_of(exp_pc));
      end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc + 32'd4) begin
        errors++; $display("FAIL stream_addr_%0d got %h/%h exp 1/%h", i, imem_req_o, imem_addr_o, exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    tick();
    tick();
    imem_ready_i = 1'b0; stall_i = 1'b1;
    checks++; if (fetch_busy_o !== 1'b0 || imem_addr_o !== 32'hBFC0_0004) begin errors++; $display("FAIL skid_pre got busy %h addr %h exp 0/bfc00004", fetch_busy_o, imem_addr_o); end
    tick();
    checks++; if (fetch_busy_o !== 1'b1) begin errors++; $display("FAIL skid_busy got %h exp 1", fetch_busy_o); end
    tick();
    checks++; if (pc_o !== 32'hBFC0_0000 || instr_o !== instr_of(32'hBFC0_0000)) begin errors++; $display("FAIL skid_hold1 got %h/%h exp bfc00000", pc_o, instr_o); end
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL skid_reqdrop got %h exp 0", imem_req_o); end
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'hBFC0_0000 || instr_o !== instr_of(32'hBFC0_0000)) begin errors++; $display("FAIL skid_hold2 got v%h %h/%h exp bfc00000", valid_o, pc_o, instr_o); end
    stall_i = 1'b0;
    tick();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'hBFC0_0004 || instr_o !== instr_of(32'hBFC0_0004)) begin errors++; $display("FAIL skid_out got v%h %h/%h exp bfc00004", valid_o, pc_o, instr_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hBFC0_0008) begin errors++; $display("FAIL skid_resume got %h/%h exp 1/bfc00008", imem_req_o, imem_addr_o); end
    imem_ready_i = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'hBFC0_0008) begin errors++; $display("FAIL skid_next got v%h %h exp bfc00008", valid_o, pc_o); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    repeat (5) tick();
    checks++; if (imem_addr_o !== 32'hBFC0_0010 || pc_o !== 32'hBFC0_000C) begin errors++; $display("FAIL drain_setup got %h/%h exp bfc00010/bfc0000c", imem_addr_o, pc_o); end
    imem_ready_i = 1'b0;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    tick();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hBFC0_0010 || valid_o !== 1'b0) begin errors++; $display("FAIL drain_hold got %h/%h v%h exp 1/bfc00010 v0", imem_req_o, imem_addr_o, valid_o); end
    checks++; if (fetch_busy_o !== 1'b1) begin errors++; $display("FAIL drain_busy got %h exp 1", fetch_busy_o); end
    tick();
    imem_ready_i = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h8000_0100 || imem_req_o !== 1'b1) begin errors++; $display("FAIL drain_done got v%h %h/%h exp v0 1/80000100", valid_o, imem_req_o, imem_addr_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8000_0100 || instr_o !== instr_of(32'h8000_0100)) begin errors++; $display("FAIL drain_target got v%h %h/%h exp 80000100", valid_o, pc_o, instr_o); end
  endtask

  task automatic test_delay_slot();
    do_reset();
    tick(); tick();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'hBFC0_0000) begin errors++; $display("FAIL ds_slot got v%h %h exp bfc00000", valid_o, pc_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    tick();
    redirect_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL ds_flush got v%h %h/%h exp v0 0/0", valid_o, pc_o, instr_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0200) begin errors++; $display("FAIL ds_addr got %h/%h exp 1/80000200", imem_req_o, imem_addr_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8000_0200) begin errors++; $display("FAIL ds_target got v%h %h exp 80000200", valid_o, pc_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC || valid_o !== 1'b0) begin errors++; $display("FAIL wrap_pre got %h v%h exp fffffffc v0", imem_addr_o, valid_o); end
    tick();
    checks++; if (imem_addr_o !== 32'h0 || pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h/%h exp 00000000/fffffffc", imem_addr_o, pc_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== instr_of(32'h0)) begin errors++; $display("FAIL wrap_slot got v%h %h/%h exp 0", valid_o, pc_o, instr_o); end
  endtask

  task automatic test_misalign();
    do_reset();
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102;
    tick();
    redirect_i = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mis_noreq got %h exp 0", imem_req_o); end
    checks++; if (misalign_o !== 1'b1 || valid_o !== 1'b1 || pc_o !== 32'h8000_0102 || instr_o !== 32'h0) begin
      errors++; $display("FAIL mis_slot got m%h v%h %h/%h exp m1 v1 80000102/0", misalign_o, valid_o, pc_o, instr_o);
    end
    tick();
    checks++; if (misalign_o !== 1'b0 || valid_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL mis_clear got m%h v%h r%h exp 0/0/0", misalign_o, valid_o, imem_req_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    tick();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0200) begin errors++; $display("FAIL mis_resume got %h/%h exp 1/80000200", imem_req_o, imem_addr_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8000_0200 || misalign_o !== 1'b0) begin errors++; $display("FAIL mis_target got v%h %h m%h exp 80000200", valid_o, pc_o, misalign_o); end
`else
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL align_force got %h/%h exp 1/80000100", imem_req_o, imem_addr_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8000_0100) begin errors++; $display("FAIL align_slot got v%h %h exp 80000100", valid_o, pc_o); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    imem_ready_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'hBFC0_0000 || fetch_busy_o !== 1'b0) begin
      errors++; $display("FAIL midrst got %h/%h b%h exp 0/bfc00000 b0", imem_req_o, imem_addr_o, fetch_busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_boot_stream();
    test_stall_skid();
    test_redirect_drain();
    test_delay_slot();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
